// File: rtl/commit_scoreboard.sv
// Commit-trace checker.
// Expected retire records are queued in a small FIFO. Each DUT commit is
// compared in order against the FIFO head. The first mismatch, timeout,
// underflow or commit after the final record is captured and held until reset.
module commit_scoreboard #(
    parameter int XLEN    = 32,
    parameter int RADDR   = 5,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       exp_valid_i,
    output logic                       exp_ready_o,
    input  logic [XLEN-1:0]            exp_pc_i,
    input  logic                       exp_we_i,
    input  logic [RADDR-1:0]           exp_rd_i,
    input  logic [XLEN-1:0]            exp_data_i,
    input  logic                       exp_last_i,
    input  logic                       cmt_valid_i,
    input  logic [XLEN-1:0]            cmt_pc_i,
    input  logic                       cmt_we_i,
    input  logic [RADDR-1:0]           cmt_rd_i,
    input  logic [XLEN-1:0]            cmt_data_i,
    output logic [1:0]                 state_o,
    output logic                       fail_o,
    output logic [2:0]                 err_code_o,
    output logic [XLEN-1:0]            err_pc_o,
    output logic [15:0]                match_cnt_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    localparam logic [2:0] ERR_NONE       = 3'd0;
    localparam logic [2:0] ERR_PC         = 3'd1;
    localparam logic [2:0] ERR_WE         = 3'd2;
    localparam logic [2:0] ERR_RD         = 3'd3;
    localparam logic [2:0] ERR_DATA       = 3'd4;
    localparam logic [2:0] ERR_UNDERFLOW  = 3'd5;
    localparam logic [2:0] ERR_TIMEOUT    = 3'd6;
    localparam logic [2:0] ERR_AFTER_LAST = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10,
        S_FAIL = 2'b11
    } state_t;

    state_t           state, state_nxt;
    logic [2:0]       err_code, err_code_nxt;
    logic [XLEN-1:0]  err_pc, err_pc_nxt;
    logic [15:0]      match_cnt, match_cnt_nxt;
    logic [TW-1:0]    timer, timer_nxt;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    level;
    logic             push, pop;

    logic [XLEN-1:0]  mem_pc   [DEPTH];
    logic             mem_we   [DEPTH];
    logic [RADDR-1:0] mem_rd   [DEPTH];
    logic [XLEN-1:0]  mem_data [DEPTH];
    logic             mem_last [DEPTH];

    logic [XLEN-1:0]  head_pc;
    logic             head_we_eff;
    logic [RADDR-1:0] head_rd;
    logic [XLEN-1:0]  head_data;
    logic             head_last;
    logic             cmt_we_eff;
    logic [2:0]       cmp_err;

    // Pushes are accepted only while there is room and the checker is still live.
    assign exp_ready_o = (level < LW'(DEPTH)) && ((state == S_IDLE) || (state == S_RUN));
    assign push        = exp_valid_i && exp_ready_o;

    assign head_pc     = mem_pc[rd_ptr];
    assign head_rd     = mem_rd[rd_ptr];
    assign head_data   = mem_data[rd_ptr];
    assign head_last   = mem_last[rd_ptr];
    assign head_we_eff = mem_we[rd_ptr] && (head_rd != '0);
    assign cmt_we_eff  = cmt_we_i && (cmt_rd_i != '0);

    assign state_o     = state;
    assign fail_o      = (state == S_FAIL);
    assign err_code_o  = err_code;
    assign err_pc_o    = err_pc;
    assign match_cnt_o = match_cnt;
    assign level_o     = level;

    // Record storage; needs no reset because the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_pc[wr_ptr]   <= exp_pc_i;
            mem_we[wr_ptr]   <= exp_we_i;
            mem_rd[wr_ptr]   <= exp_rd_i;
            mem_data[wr_ptr] <= exp_data_i;
            mem_last[wr_ptr] <= exp_last_i;
        end
    end

    // Compare the head record against the commit, reporting the highest-priority difference.
    always_comb begin
        cmp_err = ERR_NONE;
        if (head_pc != cmt_pc_i) begin
            cmp_err = ERR_PC;
        end else if (head_we_eff != cmt_we_eff) begin
            cmp_err = ERR_WE;
        end else if (head_we_eff) begin
            if (head_rd != cmt_rd_i) begin
                cmp_err = ERR_RD;
            end else if (head_data != cmt_data_i) begin
                cmp_err = ERR_DATA;
            end
        end
    end

    // Next-state logic: decides pop, match counting, timeout and first-error capture.
    always_comb begin
        state_nxt     = state;
        err_code_nxt  = err_code;
        err_pc_nxt    = err_pc;
        match_cnt_nxt = match_cnt;
        timer_nxt     = timer;
        pop           = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmt_valid_i) begin
                    state_nxt    = S_FAIL;
                    err_code_nxt = ERR_UNDERFLOW;
                    err_pc_nxt   = cmt_pc_i;
                end else if (push) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (cmt_valid_i) begin
                    timer_nxt = '0;
                    if (level == '0) begin
                        state_nxt    = S_FAIL;
                        err_code_nxt = ERR_UNDERFLOW;
                        err_pc_nxt   = cmt_pc_i;
                    end else if (cmp_err != ERR_NONE) begin
                        state_nxt    = S_FAIL;
                        err_code_nxt = cmp_err;
                        err_pc_nxt   = head_pc;
                    end else begin
                        pop = 1'b1;
                        if (match_cnt != 16'hFFFF) begin
                            match_cnt_nxt = match_cnt + 16'd1;
                        end
                        if (head_last) begin
                            state_nxt = S_DONE;
                        end
                    end
                end else if (level == '0) begin
                    timer_nxt = '0;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    state_nxt    = S_FAIL;
                    err_code_nxt = ERR_TIMEOUT;
                    err_pc_nxt   = head_pc;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            S_DONE: begin
                if (cmt_valid_i) begin
                    state_nxt    = S_FAIL;
                    err_code_nxt = ERR_AFTER_LAST;
                    err_pc_nxt   = cmt_pc_i;
                end
            end
            default: begin
            end
        endcase
    end

    // State, capture registers and FIFO pointers; reset overrides everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            err_code  <= ERR_NONE;
            err_pc    <= '0;
            match_cnt <= '0;
            timer     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
        end else begin
            state     <= state_nxt;
            err_code  <= err_code_nxt;
            err_pc    <= err_pc_nxt;
            match_cnt <= match_cnt_nxt;
            timer     <= timer_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_commit_scoreboard.sv
// Directed bench for commit_scoreboard: hand-computed expectations for
// in-order matching, each error code, FIFO full/no-bypass, timeout and reset.
module tb_commit_scoreboard;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        exp_valid_i;
    logic        exp_ready_o;
    logic [31:0] exp_pc_i;
    logic        exp_we_i;
    logic [4:0]  exp_rd_i;
    logic [31:0] exp_data_i;
    logic        exp_last_i;
    logic        cmt_valid_i;
    logic [31:0] cmt_pc_i;
    logic        cmt_we_i;
    logic [4:0]  cmt_rd_i;
    logic [31:0] cmt_data_i;
    logic [1:0]  state_o;
    logic        fail_o;
    logic [2:0]  err_code_o;
    logic [31:0] err_pc_o;
    logic [15:0] match_cnt_o;
    logic [3:0]  level_o;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [31:0] ST_IDLE = 32'd0;
    localparam logic [31:0] ST_RUN  = 32'd1;
    localparam logic [31:0] ST_DONE = 32'd2;
    localparam logic [31:0] ST_ERR  = 32'd3;

    commit_scoreboard #(.XLEN(32), .RADDR(5), .DEPTH(8), .TIMEOUT(64)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .exp_valid_i (exp_valid_i),
        .exp_ready_o (exp_ready_o),
        .exp_pc_i    (exp_pc_i),
        .exp_we_i    (exp_we_i),
        .exp_rd_i    (exp_rd_i),
        .exp_data_i  (exp_data_i),
        .exp_last_i  (exp_last_i),
        .cmt_valid_i (cmt_valid_i),
        .cmt_pc_i    (cmt_pc_i),
        .cmt_we_i    (cmt_we_i),
        .cmt_rd_i    (cmt_rd_i),
        .cmt_data_i  (cmt_data_i),
        .state_o     (state_o),
        .fail_o      (fail_o),
        .err_code_o  (err_code_o),
        .err_pc_o    (err_pc_o),
        .match_cnt_o (match_cnt_o),
        .level_o     (level_o)
    );

    // Free-running 10-unit clock.
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, let the edge sample them, then settle 1 unit past it.
    task automatic applyStimulus(input logic ev, input logic [31:0] epc, input logic ewe,
                                 input logic [4:0] erd, input logic [31:0] edata, input logic elast,
                                 input logic cv, input logic [31:0] cpc, input logic cwe,
                                 input logic [4:0] crd, input logic [31:0] cdata);
        exp_valid_i = ev;  exp_pc_i = epc;  exp_we_i = ewe;
        exp_rd_i    = erd; exp_data_i = edata; exp_last_i = elast;
        cmt_valid_i = cv;  cmt_pc_i = cpc;  cmt_we_i = cwe;
        cmt_rd_i    = crd; cmt_data_i = cdata;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pushRec(input logic [31:0] pc, input logic we, input logic [4:0] rd,
                           input logic [31:0] data, input logic last);
        applyStimulus(1, pc, we, rd, data, last, 0, 0, 0, 0, 0);
    endtask

    task automatic commitRec(input logic [31:0] pc, input logic we, input logic [4:0] rd,
                             input logic [31:0] data);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, pc, we, rd, data);
    endtask

    task automatic doReset();
        rst_i = 1'b1;
        idleCycle();
        rst_i = 1'b0;
    endtask

    task automatic checkError(input string tag, input logic [31:0] code, input logic [31:0] pc);
        checkOutput({tag, "_state"}, 32'(state_o), ST_ERR);
        checkOutput({tag, "_flag"}, 32'(fail_o), 32'd1);
        checkOutput({tag, "_code"}, 32'(err_code_o), code);
        checkOutput({tag, "_pc"}, err_pc_o, pc);
    endtask

    // Directed test sequence.
    initial begin
        rst_i = 1'b1;
        idleCycle();
        idleCycle();
        rst_i = 1'b0;
        checkOutput("rst_state", 32'(state_o), ST_IDLE);
        checkOutput("rst_flag", 32'(fail_o), 32'd0);
        checkOutput("rst_code", 32'(err_code_o), 32'd0);
        checkOutput("rst_pc", err_pc_o, 32'd0);
        checkOutput("rst_match", 32'(match_cnt_o), 32'd0);
        checkOutput("rst_level", 32'(level_o), 32'd0);
        checkOutput("rst_ready", 32'(exp_ready_o), 32'd1);

        // T1: three matching commits ending on the last record, then an extra commit.
        pushRec(32'h0, 1, 5'd1, 32'd5, 0);
        checkOutput("t1_run", 32'(state_o), ST_RUN);
        pushRec(32'h4, 1, 5'd2, 32'd7, 0);
        pushRec(32'h8, 1, 5'd3, 32'd12, 1);
        checkOutput("t1_level3", 32'(level_o), 32'd3);
        commitRec(32'h0, 1, 5'd1, 32'd5);
        commitRec(32'h4, 1, 5'd2, 32'd7);
        checkOutput("t1_mid_state", 32'(state_o), ST_RUN);
        commitRec(32'h8, 1, 5'd3, 32'd12);
        checkOutput("t1_match", 32'(match_cnt_o), 32'd3);
        checkOutput("t1_done", 32'(state_o), ST_DONE);
        checkOutput("t1_flag", 32'(fail_o), 32'd0);
        checkOutput("t1_level0", 32'(level_o), 32'd0);
        checkOutput("t1_ready_done", 32'(exp_ready_o), 32'd0);
        commitRec(32'h40, 0, 5'd0, 32'd0);
        checkError("t6_after_last", 32'd7, 32'h40);
        checkOutput("t6_match_frozen", 32'(match_cnt_o), 32'd3);

        // T2: data mismatch on the only record.
        doReset();
        pushRec(32'h0, 1, 5'd2, 32'd10, 0);
        commitRec(32'h0, 1, 5'd2, 32'd11);
        checkError("t2_data", 32'd4, 32'h0);
        checkOutput("t2_match", 32'(match_cnt_o), 32'd0);
        checkOutput("t2_ready", 32'(exp_ready_o), 32'd0);
        commitRec(32'h0, 0, 5'd0, 32'd0);
        checkOutput("t2_first_err_kept", 32'(err_code_o), 32'd4);

        // T3: fill past capacity, then pop; the blocked push in the pop cycle is dropped.
        doReset();
        for (int i = 0; i < 9; i++) begin
            if (i == 8) checkOutput("t3_ready_full", 32'(exp_ready_o), 32'd0);
            pushRec(32'(i * 4), 0, 5'd0, 32'd0, 0);
        end
        checkOutput("t3_level8", 32'(level_o), 32'd8);
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0);
        checkOutput("t3_level7", 32'(level_o), 32'd7);
        checkOutput("t3_ready", 32'(exp_ready_o), 32'd1);
        applyStimulus(1, 32'h104, 0, 0, 0, 0, 1, 32'h4, 0, 0, 0);
        checkOutput("t3_pushpop_level", 32'(level_o), 32'd7);
        checkOutput("t3_match", 32'(match_cnt_o), 32'd2);

        // T4: underflow in IDLE, x0 writes treated as no-write, underflow in RUN.
        doReset();
        commitRec(32'h20, 1, 5'd4, 32'd1);
        checkError("t4_idle_underflow", 32'd5, 32'h20);
        doReset();
        pushRec(32'h0, 1, 5'd0, 32'd5, 0);
        pushRec(32'h4, 0, 5'd0, 32'd0, 0);
        commitRec(32'h0, 1, 5'd0, 32'd123);
        commitRec(32'h4, 1, 5'd0, 32'd9);
        checkOutput("t4_x0_match", 32'(match_cnt_o), 32'd2);
        checkOutput("t4_x0_state", 32'(state_o), ST_RUN);
        commitRec(32'h50, 0, 5'd0, 32'd0);
        checkError("t4_run_underflow", 32'd5, 32'h50);

        // Remaining comparison codes: PC, write-enable, destination register.
        doReset();
        pushRec(32'h8, 0, 5'd0, 32'd0, 0);
        commitRec(32'hC, 0, 5'd0, 32'd0);
        checkOutput("pc_code", 32'(err_code_o), 32'd1);
        doReset();
        pushRec(32'h10, 1, 5'd5, 32'd1, 0);
        commitRec(32'h10, 0, 5'd5, 32'd1);
        checkError("we_err", 32'd2, 32'h10);
        doReset();
        pushRec(32'h14, 1, 5'd5, 32'd1, 0);
        commitRec(32'h14, 1, 5'd6, 32'd1);
        checkError("rd_err", 32'd3, 32'h14);

        // T5: one record and no commits; timeout lands exactly 64 edges after the push.
        doReset();
        pushRec(32'h80, 0, 5'd0, 32'd0, 0);
        for (int i = 0; i < 63; i++) idleCycle();
        checkOutput("t5_before_timeout", 32'(state_o), ST_RUN);
        idleCycle();
        checkError("t5_timeout", 32'd6, 32'h80);
        checkOutput("t5_level_frozen", 32'(level_o), 32'd1);

        // T6: reset mid-run with five records queued, with a push and commit in the reset cycle.
        doReset();
        for (int i = 0; i < 6; i++) pushRec(32'(i * 4), 0, 5'd0, 32'd0, 0);
        commitRec(32'h0, 0, 5'd0, 32'd0);
        checkOutput("t6_level5", 32'(level_o), 32'd5);
        checkOutput("t6_match1", 32'(match_cnt_o), 32'd1);
        rst_i = 1'b1;
        applyStimulus(1, 32'h200, 0, 0, 0, 0, 1, 32'h4, 0, 0, 0);
        rst_i = 1'b0;
        checkOutput("t6_rst_state", 32'(state_o), ST_IDLE);
        checkOutput("t6_rst_level", 32'(level_o), 32'd0);
        checkOutput("t6_rst_match", 32'(match_cnt_o), 32'd0);
        checkOutput("t6_rst_code", 32'(err_code_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
